// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA scanout slice: pixel/address widths,
// default 640x480@60 timing and the test-pattern colour bars.
package vga_pkg;

  localparam int COORD_W    = 10;
  localparam int PIX_ADDR_W = 2 * COORD_W;

  typedef logic [14:0] rgb555_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Bar colours left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam rgb555_t BAR_COLOURS [8] = '{
    15'h7FFF, 15'h7FE0, 15'h03FF, 15'h03E0,
    15'h7C1F, 15'h7C00, 15'h001F, 15'h0000
  };

  // Raster flags that travel alongside the RAM read; hs/vs mean "asserted".
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
    logic fs;
  } sync_flags_t;

endpackage

// File: rtl/vga_scanout_if.sv
// Frame-RAM read port: the scanout is the master, the RAM the slave.
interface vga_scanout_if
  import vga_pkg::*;
();

  logic                  rd_en;
  logic [PIX_ADDR_W-1:0] rd_addr;
  rgb555_t               rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);

endinterface

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register that keeps raster flags in step with RAM data.
module vga_sync_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // NOTE: the stages are cleared on reset because they carry data-enable;
  // a stale active bit here would push a garbage pixel out after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_scanout.sv
// VGA raster generator and frame-RAM scanout with sync/DE aligned to read data.
// Optional colour-bar source selected by build macro VGA_SCANOUT_TEST_PATTERN_EN.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int RD_LATENCY = 1,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  input  logic          pattern_sel,
`endif
  vga_scanout_if.master ram,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output rgb555_t       rgb_out,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // The output register is the last of the RD_LATENCY+2 alignment stages.
  localparam int DLY_DEPTH = RD_LATENCY + 1;

  if (H_ACTIVE > 1024 || V_ACTIVE > 1024 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_geom_err
    $error("vga_scanout: raster geometry does not fit 10-bit counters");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_lat_err
    $error("vga_scanout: RD_LATENCY must be 1..4");
  end

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W:0]   H_ACT    = (COORD_W+1)'(H_ACTIVE);
  localparam logic [COORD_W:0]   V_ACT    = (COORD_W+1)'(V_ACTIVE);
  localparam logic [COORD_W:0]   HS_BEGIN = (COORD_W+1)'(H_ACTIVE + H_FP);
  localparam logic [COORD_W:0]   HS_END   = (COORD_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W:0]   VS_BEGIN = (COORD_W+1)'(V_ACTIVE + V_FP);
  localparam logic [COORD_W:0]   VS_END   = (COORD_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic [COORD_W:0]   h_ext, v_ext;
  logic               active;
  sync_flags_t        raw_flags, dly_flags;
  rgb555_t            pix_next;

  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + COORD_W'(1);
      end else begin
        h_cnt <= h_cnt + COORD_W'(1);
      end
    end
  end

  // Compare in COORD_W+1 bits so a 1024-wide active area still works.
  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};
  assign active = (h_ext < H_ACT) && (v_ext < V_ACT);

  assign raw_flags = '{
    hs:     (h_ext >= HS_BEGIN) && (h_ext < HS_END),
    vs:     (v_ext >= VS_BEGIN) && (v_ext < VS_END),
    active: active,
    fs:     (h_cnt == '0) && (v_cnt == '0)
  };

  logic rd_req;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  assign rd_req = active && !pattern_sel;
`else
  assign rd_req = active;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      ram.rd_en   <= 1'b0;
      ram.rd_addr <= '0;
    end else if (en) begin
      ram.rd_en <= rd_req;
      if (active) ram.rd_addr <= {v_cnt, h_cnt};
    end
  end

  vga_sync_delay #(
    .DEPTH (DLY_DEPTH),
    .WIDTH ($bits(sync_flags_t))
  ) u_flag_dly (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (raw_flags),
    .q   (dly_flags)
  );

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  localparam int               BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [COORD_W:0] BAR_W_C = (COORD_W+1)'(BAR_W);

  logic [COORD_W:0] bar_quot;
  logic [2:0]       bar_idx;
  logic [3:0]       pat_dly;

  assign bar_quot = h_ext / BAR_W_C;
  assign bar_idx  = (bar_quot > (COORD_W+1)'(7)) ? 3'd7 : bar_quot[2:0];

  // Selection and bar index ride the same delay so timing matches the RAM path.
  vga_sync_delay #(
    .DEPTH (DLY_DEPTH),
    .WIDTH (4)
  ) u_pat_dly (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   ({pattern_sel, bar_idx}),
    .q   (pat_dly)
  );
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pix_next = '0;
    if (dly_flags.active) begin
      pix_next = ram.rd_data;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      if (pat_dly[3]) pix_next = BAR_COLOURS[pat_dly[2:0]];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      rgb_out     <= '0;
      frame_start <= 1'b0;
    end else if (en) begin
      hsync       <= dly_flags.hs ? SYNC_POL : ~SYNC_POL;
      vsync       <= dly_flags.vs ? SYNC_POL : ~SYNC_POL;
      de          <= dly_flags.active;
      rgb_out     <= pix_next;
      frame_start <= dly_flags.fs;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a reduced raster with a latency-2 RAM model.
module tb_vga_scanout;
  import vga_pkg::*;

  localparam int HA  = 32;
  localparam int HFP = 4;
  localparam int HSW = 6;
  localparam int HBP = 6;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VA  = 12;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int RDL = 2;
  localparam int L   = RDL + 2;

  localparam logic [18:0] RST_OUT = {1'b1, 1'b1, 1'b0, 1'b0, 15'd0};

  logic    clk;
  logic    rst;
  logic    en;
  logic    hsync, vsync, de, frame_start;
  rgb555_t rgb_out;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  logic    pattern_sel;
  initial pattern_sel = 1'b0;
`endif

  vga_scanout_if ram_if ();

  vga_scanout #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .RD_LATENCY (RDL), .SYNC_POL (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    .pattern_sel (pattern_sel),
`endif
    .ram         (ram_if),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .rgb_out     (rgb_out),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data = address[14:0], RDL cycles after the request, frozen by en=0.
  logic [PIX_ADDR_W-1:0] ram_pipe [RDL];
  always @(posedge clk) begin
    if (en) begin
      ram_pipe[0] <= ram_if.rd_addr;
      for (int i = 1; i < RDL; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
  end
  assign ram_if.rd_data = ram_pipe[RDL-1][14:0];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard state: independent raster model and the expected-output queue.
  logic [18:0]           exp_q [$];
  logic [18:0]           exp_now;
  int                    mh, mv;
  logic                  m_rd_en;
  logic [PIX_ADDR_W-1:0] m_rd_addr;

  function automatic logic [18:0] model_out(input int h, input int v);
    logic                  act, hs, vs, fs;
    logic [PIX_ADDR_W-1:0] a;
    act = (h < HA) && (v < VA);
    hs  = (h >= HA + HFP) && (h < HA + HFP + HSW);
    vs  = (v >= VA + VFP) && (v < VA + VFP + VSW);
    fs  = (h == 0) && (v == 0);
    a   = {10'(v), 10'(h)};
    return {~hs, ~vs, act, fs, act ? a[14:0] : 15'd0};
  endfunction

  task automatic sb_init();
    exp_q.delete();
    for (int i = 0; i < L - 1; i++) exp_q.push_back(RST_OUT);
    exp_now   = RST_OUT;
    mh        = 0;
    mv        = 0;
    m_rd_en   = 1'b0;
    m_rd_addr = '0;
  endtask

  // Called at a falling edge: compare current outputs, then clock one cycle.
  task automatic step(input logic en_v);
    logic [18:0] nxt;
    nxt = exp_now;
    check("out", {13'd0, hsync, vsync, de, frame_start, rgb_out}, {13'd0, exp_now});
    check("rd_en", {31'd0, ram_if.rd_en}, {31'd0, m_rd_en});
    check("rd_addr", {12'd0, ram_if.rd_addr}, {12'd0, m_rd_addr});
    en = en_v;
    if (en_v) begin
      exp_q.push_back(model_out(mh, mv));
      nxt = exp_q.pop_front();
      m_rd_en = (mh < HA) && (mv < VA);
      if (m_rd_en) m_rd_addr = {10'(mv), 10'(mh)};
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    exp_now = nxt;
  endtask

  task automatic measure_line();
    int  t_rise, t_fall, t_hs0, t_hs1, t_rise2;
    logic prev_de, prev_hs;
    t_rise = -1; t_fall = -1; t_hs0 = -1; t_hs1 = -1; t_rise2 = -1;
    prev_de = de;
    prev_hs = hsync;
    for (int t = 0; t < 2 * HT * VT; t++) begin
      step(1'b1);
      if (t_rise < 0 && de && !prev_de) t_rise = t;
      else if (t_rise >= 0 && t_fall < 0 && !de && prev_de) t_fall = t;
      else if (t_fall >= 0 && t_hs0 < 0 && !hsync && prev_hs) t_hs0 = t;
      else if (t_hs0 >= 0 && t_hs1 < 0 && hsync && !prev_hs) t_hs1 = t;
      else if (t_hs1 >= 0 && de && !prev_de) begin
        t_rise2 = t;
        break;
      end
      prev_de = de;
      prev_hs = hsync;
    end
    check("line_found", {31'd0, t_rise2 >= 0}, 32'd1);
    check("de_width", t_fall - t_rise, HA);
    check("hs_offset", t_hs0 - t_fall, HFP);
    check("hs_width", t_hs1 - t_hs0, HSW);
    check("line_period", t_rise2 - t_rise, HT);
  endtask

  task automatic measure_frame();
    int fs_cnt, vs_low, vs_first;
    for (int i = 0; i < 2 * HT * VT && !frame_start; i++) step(1'b1);
    check("frame_seek", {31'd0, frame_start}, 32'd1);
    fs_cnt = 0; vs_low = 0; vs_first = -1;
    for (int t = 1; t <= HT * VT; t++) begin
      step(1'b1);
      if (frame_start) fs_cnt++;
      if (!vsync) begin
        vs_low++;
        if (vs_first < 0) vs_first = t;
      end
    end
    check("fs_per_frame", fs_cnt, 1);
    check("vs_width", vs_low, VSW * HT);
    check("vs_start", vs_first, (VA + VFP) * HT);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst = 1'b0;
    en  = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_hsync", {31'd0, hsync}, 32'd1);
    check("rst_vsync", {31'd0, vsync}, 32'd1);
    check("rst_de", {31'd0, de}, 32'd0);
    check("rst_rgb", {17'd0, rgb_out}, 32'd0);
    check("rst_rd_en", {31'd0, ram_if.rd_en}, 32'd0);
    check("rst_fs", {31'd0, frame_start}, 32'd0);

    // First-pixel latency.
    sb_init();
    rst = 1'b1;
    step(1'b1);
    check("first_rd_en", {31'd0, ram_if.rd_en}, 32'd1);
    check("first_rd_addr", {12'd0, ram_if.rd_addr}, 32'd0);
    for (int i = 1; i < L; i++) step(1'b1);
    check("first_de", {31'd0, de}, 32'd1);
    check("first_fs", {31'd0, frame_start}, 32'd1);
    check("first_rgb", {17'd0, rgb_out}, 32'd0);
    for (int i = 0; i < 2 * HT + 5; i++) step(1'b1);
    check("pix_5_2", {17'd0, rgb_out}, (2 << 10) | 5);

    measure_line();

    // Stall mid-line at x=10 on an active line.
    for (int i = 0; i < 2 * HT * VT && !(mh == 10 && mv < VA); i++) step(1'b1);
    check("stall_seek", {31'd0, mh == 10 && mv < VA}, 32'd1);
    repeat (7) step(1'b0);
    repeat (3 * HT) step(1'b1);

    // Random enable gaps.
    for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0);

    measure_frame();

    // Reset mid-frame on line 5.
    for (int i = 0; i < 2 * HT * VT && !(mv == 5 && mh == 3); i++) step(1'b1);
    check("mid_rst_seek", {31'd0, mv == 5 && mh == 3}, 32'd1);
    rst = 1'b0;
    en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_de", {31'd0, de}, 32'd0);
    check("mid_rst_rgb", {17'd0, rgb_out}, 32'd0);
    check("mid_rst_fs", {31'd0, frame_start}, 32'd0);
    check("mid_rst_rd_en", {31'd0, ram_if.rd_en}, 32'd0);
    sb_init();
    rst = 1'b1;
    cnt = 0;
    while (!frame_start && cnt < 4 * L) begin
      step(1'b1);
      cnt++;
    end
    check("fs_after_rst", cnt, L);
    repeat (2 * HT) step(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
